// File: rtl/serial_sub8.sv
`default_nettype none
// ============================================================================
// Module   : serial_sub8
// Brief    : Bit-serial WIDTH-bit subtractor, D = A - B - Bi, LSB first,
//            one full-subtractor cell plus shift registers, with a
//            start/ready/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module serial_sub8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bi,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bo,
  output logic             ovf
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;        // minuend, shifted right each RUN cycle
  logic [WIDTH-1:0] b_q, b_d;        // subtrahend, shifted right each RUN cycle
  logic             br_q, br_d;      // running borrow
  logic [CW-1:0]    cnt_q, cnt_d;    // bit index being processed
  logic [WIDTH-1:0] res_q, res_d;    // partial result, filled from the MSB end
  logic             a_msb_q, a_msb_d;  // sign bits kept for the overflow test,
  logic             b_msb_q, b_msb_d;  // since the operands are shifted away
  logic [WIDTH-1:0] diff_q, diff_d;  // published result, only updated at completion
  logic             bo_q, bo_d;
  logic             ovf_q, ovf_d;

  logic w_d_bit;
  logic w_br_next;

  // Full-subtractor cell operating on the current LSBs and the borrow flop
  always_comb begin
    w_d_bit   = a_q[0] ^ b_q[0] ^ br_q;
    w_br_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  end

  // Next-state logic: capture on accept, shift during RUN, publish on completion
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    diff_d  = diff_q;
    bo_d    = bo_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          br_d    = Bi;
          cnt_d   = '0;
          a_msb_d = A[WIDTH-1];
          b_msb_d = B[WIDTH-1];
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        res_d = {w_d_bit, res_q[WIDTH-1:1]};
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        br_d  = w_br_next;
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          // The last difference bit is the result MSB, so the overflow
          // test can use it directly without waiting for res_q.
          diff_d  = {w_d_bit, res_q[WIDTH-1:1]};
          bo_d    = w_br_next;
          ovf_d   = (a_msb_q ^ b_msb_q) & (w_d_bit ^ a_msb_q);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      diff_q  <= '0;
      bo_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      diff_q  <= diff_d;
      bo_q    <= bo_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake and result outputs decoded from registered state
  always_comb begin
    ready = (state_q == S_IDLE);
    done  = (state_q == S_DONE);
    D     = diff_q;
    Bo    = bo_q;
    ovf   = ovf_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_sub8.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_sub8
// Brief    : Self-checking bench for serial_sub8: directed cases plus a
//            randomized back-to-back stream against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_sub8;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bi;
  logic         ready;
  logic         done;
  logic [W-1:0] d;
  logic         bo;
  logic         ovf;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bi;
    int           acc;
  } op_t;

  op_t q[$];

  serial_sub8 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (a),
    .B     (b),
    .Bi    (bi),
    .ready (ready),
    .done  (done),
    .D     (d),
    .Bo    (bo),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {ovf, Bo, D} from plain wide unsigned subtraction
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mbi);
    logic [W:0]   r;
    logic [W-1:0] md;
    logic         mo;
    r  = {1'b0, ma} - {1'b0, mb} - (W+1)'(mbi);
    md = r[W-1:0];
    mo = (ma[W-1] ^ mb[W-1]) & (md[W-1] ^ ma[W-1]);
    return {mo, r};
  endfunction

  // One operation from idle with explicit expected results
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tbi, input logic [W-1:0] ed, input logic ebo,
                        input logic eovf);
    int found;
    int lat;
    found = 0;
    lat   = 0;
    @(negedge clk);
    check({tag, " ready_before"}, ready, 1);
    a = ta; b = tb_v; bi = tbi; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 20 && found == 0; k++) begin
      @(negedge clk);
      if (done) begin
        found = 1;
        lat   = k - 1;
      end
    end
    check({tag, " done_seen"}, found, 1);
    if (found != 0) begin
      check({tag, " latency"}, lat, W);
      check({tag, " D"}, d, ed);
      check({tag, " Bo"}, bo, ebo);
      check({tag, " ovf"}, ovf, eovf);
      check({tag, " ready_with_done"}, ready, 0);
      @(negedge clk);
      check({tag, " ready_after"}, ready, 1);
      check({tag, " done_after"}, done, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ndone;
    int cnt;
    int busy;
    int cycle;
    int last_done;
    int first_d;
    logic [W+1:0] e;
    op_t o;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bi = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset ready", ready, 1);
    check("reset done", done, 0);
    check("reset D", d, 0);
    check("reset Bo", bo, 0);
    check("reset ovf", ovf, 0);

    // Directed arithmetic and boundary cases
    run_op("t05m03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    run_op("t00m01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    run_op("t01mFFb", 8'h01, 8'hFF, 1'b1, 8'h01, 1'b1, 1'b0);
    run_op("t80m01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run_op("t7FmFF", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    run_op("tAeqB", 8'h3C, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0);
    run_op("t00m00b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);

    // start pulsed mid-operation with new operands must be ignored
    @(negedge clk);
    a = 8'h10; b = 8'h01; bi = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 start = 1'b1; a = 8'hFF; b = 8'hFF;
    @(posedge clk);
    #2 start = 1'b0;
    cnt = 0;
    first_d = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) begin
        cnt++;
        if (first_d < 0) first_d = int'(d);
      end
    end
    check("ignore done_count", cnt, 1);
    check("ignore D", first_d, 32'h0F);

    // Asynchronous reset in the middle of RUN aborts the operation
    @(negedge clk);
    a = 8'hAA; b = 8'h55; bi = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort D", d, 0);
    check("abort Bo", bo, 0);
    check("abort ovf", ovf, 0);
    check("abort done", done, 0);
    check("abort ready", ready, 1);
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) cnt++;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("abort no_done", cnt, 0);
    run_op("tAAm55", 8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1);

    // Random stream with start held high; the bench tracks acceptance itself
    ndone = 0; busy = 0; cycle = 0; last_done = -1;
    while (ndone < 1000 && cycle < 1000 * (W + 2) + 50) begin
      @(negedge clk);
      if (done) begin
        if (q.size() == 0) begin
          check("rnd unexpected_done", 1, 0);
        end else begin
          o = q.pop_front();
          e = model(o.a, o.b, o.bi);
          check("rnd D", d, e[W-1:0]);
          check("rnd Bo", bo, e[W]);
          check("rnd ovf", ovf, e[W+1]);
          check("rnd latency", cycle - o.acc, W);
        end
        check("rnd ready_with_done", ready, 0);
        if (last_done >= 0) check("rnd spacing", cycle - last_done, W + 2);
        last_done = cycle;
        ndone++;
      end
      a = W'($urandom); b = W'($urandom); bi = 1'($urandom); start = 1'b1;
      @(posedge clk);
      cycle++;
      if (busy == 0) begin
        q.push_back('{a, b, bi, cycle});
        busy = W + 1;
      end else begin
        busy--;
      end
    end
    check("rnd done_count", ndone, 1000);
    start = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
